// File: rtl/v810_pkg.sv
// Shared V810 fetch definitions: reset vector, prefetch queue entry and the
// instruction length decode used by the fetch unit.
package v810_pkg;

  localparam logic [31:0] V810_RESET_VECTOR = 32'hFFFF_FFF0;

  // One buffered halfword together with the halfword address it was fetched from.
  typedef struct packed {
    logic [15:0] hw;
    logic [31:1] addr;
  } v810_fq_entry_t;

  // Opcodes 6'h28 and above use the 32-bit format; Bcond (6'h20-6'h27) stays short.
  function automatic logic v810_is_long(input logic [5:0] op);
    return op[5] & (op[4] | op[3]);
  endfunction

endpackage

// File: rtl/v810_fetch_queue.sv
// Circular halfword prefetch queue: push one entry, pop zero to two entries,
// and flush, all in a single cycle.
module v810_fetch_queue
  import v810_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  v810_fq_entry_t             i_push_data,
  input  logic [1:0]                 i_pop_n,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH):0]     o_count,
  output v810_fq_entry_t             o_head0,
  output logic [15:0]                o_head1_hw
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  v810_fq_entry_t  r_mem [DEPTH];
  logic [PtrW-1:0] r_head;
  logic [PtrW-1:0] r_tail;
  logic [CntW-1:0] r_count;

  logic [PtrW-1:0] w_head_next;
  logic [PtrW-1:0] w_tail_next;
  logic [CntW-1:0] w_count_next;
  logic [PtrW-1:0] w_head1_idx;
  logic            w_write;

  assign w_write     = i_push & ~i_flush;
  assign w_head1_idx = r_head + PtrW'(1);

  always_comb begin
    w_head_next  = r_head;
    w_tail_next  = r_tail;
    w_count_next = r_count;
    if (i_flush) begin
      w_head_next  = '0;
      w_tail_next  = '0;
      w_count_next = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      w_head_next  = r_head + PtrW'(i_pop_n);
      w_tail_next  = r_tail + PtrW'(i_push);
      w_count_next = r_count + CntW'(i_push) - CntW'(i_pop_n);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  assign o_count    = r_count;
  assign o_head0    = r_mem[r_head];
  assign o_head1_hw = r_mem[w_head1_idx].hw;

endmodule

// File: rtl/v810_fetch.sv
// V810 instruction fetch unit: drives the halfword bus, buffers halfwords and
// presents whole 16/32-bit instructions, with branch redirect and clock enable.
module v810_fetch
  import v810_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = V810_RESET_VECTOR
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  output logic [31:0] IA,
  output logic        IREQ,
  input  logic        IACK,
  input  logic [15:0] ID,
  input  logic        BR_VALID,
  input  logic [30:0] BR_TARGET,
  output logic        INST_VALID,
  input  logic        INST_READY,
  output logic [31:0] INST,
  output logic        INST_LONG,
  output logic [30:0] INST_PC
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [31:1]     r_fpc;
  logic [31:1]     w_fpc_next;
  logic [CntW-1:0] w_count;
  v810_fq_entry_t  w_head0;
  logic [15:0]     w_head1_hw;
  v810_fq_entry_t  w_push_data;
  logic            w_redirect;
  logic            w_accept;
  logic            w_long;
  logic            w_pop;
  logic [1:0]      w_pop_n;

  assign w_redirect = CE & BR_VALID;
  assign w_accept   = CE & IREQ & IACK & ~BR_VALID;
  assign w_long     = v810_is_long(w_head0.hw[15:10]);
  // A redirect discards any pop in the same cycle.
  assign w_pop      = CE & INST_VALID & INST_READY & ~BR_VALID;
  assign w_pop_n    = w_pop ? (w_long ? 2'd2 : 2'd1) : 2'd0;

  assign w_push_data.hw   = ID;
  assign w_push_data.addr = r_fpc;

  always_comb begin
    w_fpc_next = r_fpc;
    if (w_redirect) begin
      w_fpc_next = BR_TARGET;
    end else if (w_accept) begin
      w_fpc_next = r_fpc + 31'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_fpc <= RESET_PC[31:1];
    end else begin
      r_fpc <= w_fpc_next;
    end
  end

  v810_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_push      (w_accept),
    .i_push_data (w_push_data),
    .i_pop_n     (w_pop_n),
    .i_flush     (w_redirect),
    .o_count     (w_count),
    .o_head0     (w_head0),
    .o_head1_hw  (w_head1_hw)
  );

  assign IA         = {r_fpc, 1'b0};
  assign IREQ       = (w_count < CntW'(DEPTH));
  assign INST_VALID = ((w_count >= CntW'(1)) & ~w_long) | ((w_count >= CntW'(2)) & w_long);
  assign INST_LONG  = w_long;
  assign INST       = w_long ? {w_head0.hw, w_head1_hw} : {16'h0000, w_head0.hw};
  assign INST_PC    = w_head0.addr;

endmodule

// File: tb/tb_v810_fetch.sv
// Directed bench for v810_fetch: a small instruction memory answers on IA and
// each step checks hand-computed outputs after the clock edge.
module tb_v810_fetch;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CE;
  logic [31:0] IA;
  logic        IREQ;
  logic        IACK;
  logic [15:0] ID;
  logic        BR_VALID;
  logic [30:0] BR_TARGET;
  logic        INST_VALID;
  logic        INST_READY;
  logic [31:0] INST;
  logic        INST_LONG;
  logic [30:0] INST_PC;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  v810_fetch #(
    .DEPTH    (4),
    .RESET_PC (32'hFFFF_FFF0)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .CE         (CE),
    .IA         (IA),
    .IREQ       (IREQ),
    .IACK       (IACK),
    .ID         (ID),
    .BR_VALID   (BR_VALID),
    .BR_TARGET  (BR_TARGET),
    .INST_VALID (INST_VALID),
    .INST_READY (INST_READY),
    .INST       (INST),
    .INST_LONG  (INST_LONG),
    .INST_PC    (INST_PC)
  );

  // Instruction memory: a few fixed words, otherwise a short opcode built from the address.
  function automatic logic [15:0] hw_at(input logic [31:0] a);
    case (a)
      32'hFFFF_FFF0: return 16'h1C01;
      32'hFFFF_FFF2: return 16'hA800;
      32'hFFFF_FFF4: return 16'h0010;
      32'h0000_1000: return 16'hB000;
      32'h0000_1002: return 16'h1234;
      default:       return {4'h0, a[12:1]};
    endcase
  endfunction

  assign ID = hw_at(IA);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET      = 1'b1;
    CE         = 1'b1;
    IACK       = 1'b0;
    BR_VALID   = 1'b0;
    BR_TARGET  = '0;
    INST_READY = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(INST_VALID), 32'd0);
    check("rst_ireq", 32'(IREQ), 32'd1);
    check("rst_ia", IA, 32'hFFFF_FFF0);

    // Streaming fetch with the consumer always ready.
    RESET      = 1'b0;
    IACK       = 1'b1;
    INST_READY = 1'b1;
    tick();
    check("s1_valid", 32'(INST_VALID), 32'd1);
    check("s1_inst", INST, 32'h0000_1C01);
    check("s1_pc", 32'(INST_PC), 32'h7FFF_FFF8);
    check("s1_long", 32'(INST_LONG), 32'd0);
    check("s1_ia", IA, 32'hFFFF_FFF2);
    tick();
    check("s2_half_long", 32'(INST_VALID), 32'd0);
    tick();
    check("s3_valid", 32'(INST_VALID), 32'd1);
    check("s3_inst", INST, 32'hA800_0010);
    check("s3_long", 32'(INST_LONG), 32'd1);
    check("s3_pc", 32'(INST_PC), 32'h7FFF_FFF9);
    tick();
    check("s4_inst", INST, 32'h0000_0FFB);
    check("s4_pc", 32'(INST_PC), 32'h7FFF_FFFB);

    // Redirect to 0x200, then fill the queue with the consumer stalled.
    IACK       = 1'b0;
    INST_READY = 1'b0;
    BR_VALID   = 1'b1;
    BR_TARGET  = 31'h0000_0100;
    tick();
    check("br1_valid", 32'(INST_VALID), 32'd0);
    check("br1_ia", IA, 32'h0000_0200);
    BR_VALID = 1'b0;
    IACK     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("fill_ireq", 32'(IREQ), 32'd1);
      tick();
    end
    check("full_ireq", 32'(IREQ), 32'd0);
    check("full_ia", IA, 32'h0000_0208);
    check("full_inst", INST, 32'h0000_0100);
    tick();
    check("full_hold_ia", IA, 32'h0000_0208);
    INST_READY = 1'b1;
    tick();
    check("pop_ireq", 32'(IREQ), 32'd1);
    check("pop_inst", INST, 32'h0000_0101);
    check("pop_pc", 32'(INST_PC), 32'h0000_0101);
    check("pop_ia", IA, 32'h0000_0208);

    // Redirect collides with an ack and a pop; both must be dropped.
    BR_VALID  = 1'b1;
    BR_TARGET = 31'h0000_0800;
    tick();
    check("br2_valid", 32'(INST_VALID), 32'd0);
    check("br2_ia", IA, 32'h0000_1000);
    check("br2_ireq", 32'(IREQ), 32'd1);
    BR_VALID   = 1'b0;
    INST_READY = 1'b0;
    tick();
    check("lh_valid0", 32'(INST_VALID), 32'd0);
    check("lh_ia", IA, 32'h0000_1002);
    IACK = 1'b0;
    tick();
    check("lh_valid1", 32'(INST_VALID), 32'd0);
    tick();
    check("lh_valid2", 32'(INST_VALID), 32'd0);
    IACK = 1'b1;
    tick();
    check("lh_valid3", 32'(INST_VALID), 32'd1);
    check("lh_inst", INST, 32'hB000_1234);
    check("lh_long", 32'(INST_LONG), 32'd1);
    check("lh_pc", 32'(INST_PC), 32'h0000_0800);
    IACK       = 1'b0;
    INST_READY = 1'b1;
    tick();
    check("lh_popped", 32'(INST_VALID), 32'd0);

    // Fetch PC wrap at the top of the address space.
    INST_READY = 1'b0;
    BR_VALID   = 1'b1;
    BR_TARGET  = 31'h7FFF_FFFF;
    tick();
    check("wrap_ia0", IA, 32'hFFFF_FFFE);
    BR_VALID = 1'b0;
    IACK     = 1'b1;
    tick();
    check("wrap_ia1", IA, 32'h0000_0000);
    check("wrap_inst", INST, 32'h0000_0FFF);
    check("wrap_pc", 32'(INST_PC), 32'h7FFF_FFFF);

    // Clock enable low: ack and ready present but nothing may move.
    CE         = 1'b0;
    INST_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ce_ia", IA, 32'h0000_0000);
      check("ce_valid", 32'(INST_VALID), 32'd1);
      check("ce_inst", INST, 32'h0000_0FFF);
    end
    CE         = 1'b1;
    INST_READY = 1'b0;
    tick();
    check("ce_resume_ia", IA, 32'h0000_0002);
    check("ce_resume_inst", INST, 32'h0000_0FFF);

    // Asynchronous reset between the halves of a long instruction.
    IACK      = 1'b0;
    BR_VALID  = 1'b1;
    BR_TARGET = 31'h0000_0800;
    tick();
    BR_VALID = 1'b0;
    IACK     = 1'b1;
    tick();
    check("ar_pre_ia", IA, 32'h0000_1002);
    IACK = 1'b0;
    #3;
    RESET = 1'b1;
    #1;
    check("ar_valid", 32'(INST_VALID), 32'd0);
    check("ar_ia", IA, 32'hFFFF_FFF0);
    check("ar_ireq", 32'(IREQ), 32'd1);
    tick();
    check("ar_hold_ia", IA, 32'hFFFF_FFF0);
    RESET = 1'b0;
    IACK  = 1'b1;
    tick();
    check("ar_post_valid", 32'(INST_VALID), 32'd1);
    check("ar_post_inst", INST, 32'h0000_1C01);
    check("ar_post_pc", 32'(INST_PC), 32'h7FFF_FFF8);
    check("ar_post_ia", IA, 32'hFFFF_FFF2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
